// File: rtl/kitchen_pkg.sv
// Shared dish encodings and serving FSM states for the kitchen blocks.
// Imported by the order checker and its button front end.
package kitchen_pkg;

    localparam logic [11:0] CHICKEN_RICE = 12'b011_000_001_000;
    localparam logic [11:0] ONION_SOUP   = 12'b000_000_000_001;
    localparam logic [11:0] TOMATO_SOUP  = 12'b000_001_000_000;
    localparam logic [11:0] TOMATO_RICE  = 12'b000_001_001_000;
    localparam logic [11:0] DISH_EMPTY   = 12'h000;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ACCEPT,
        REJECT,
        COOLDOWN
    } state_e;

    // One-hot of the lowest set bit, so duplicate matches fill one slot only.
    function automatic logic [2:0] lowest_one(input logic [2:0] v);
        lowest_one = v & (~v + 3'd1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous pushbutton plus a
// one-cycle rising-edge pulse on the synchronized level.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = btn_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/order_checker.sv
// Arbitrates a serve press against the three active orders and keeps
// sticky per-slot done flags, score/miss counters and consume pulses.
module order_checker
    import kitchen_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 10_000_000,
    parameter int SCORE_W         = 8,
    parameter int MISS_W          = 4
) (
    input  logic               basys_clk,
    input  logic               rst_n,
    input  logic               serve_btn,
    input  logic [11:0]        order_1,
    input  logic [11:0]        order_2,
    input  logic [11:0]        order_3,
    input  logic [11:0]        inventory,
    output logic [2:0]         orders_done,
    output logic               inv_consume,
    output logic               serve_ok,
    output logic               serve_bad,
    output logic               all_done,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses
);

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    logic btn_edge;

    btn_sync_edge u_sync (
        .clk    (basys_clk),
        .rst_n  (rst_n),
        .btn_in (serve_btn),
        .pulse  (btn_edge)
    );

    logic [11:0] order_w [3];

    assign order_w[0] = order_1;
    assign order_w[1] = order_2;
    assign order_w[2] = order_3;

    state_e             state_q, state_d;
    logic [11:0]        plate_q, plate_d;
    logic [2:0]         slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         done_q, done_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               ok_q, ok_d;
    logic               bad_q, bad_d;
    logic               cons_q, cons_d;
    logic [11:0]        shadow_q [3];
    logic [11:0]        shadow_d [3];
    logic [2:0]         changed;
    logic [2:0]         match;

    always_comb begin
        changed = '0;
        match   = '0;
        for (int i = 0; i < 3; i++) begin
            shadow_d[i] = order_w[i];
            changed[i]  = (order_w[i] != shadow_q[i]);
            match[i]    = (order_w[i] == plate_q) && !done_q[i]
                          && (plate_q != DISH_EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        plate_d = plate_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        score_d = score_q;
        miss_d  = miss_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
        cons_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_edge) begin
                    plate_d = inventory;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                slot_d  = lowest_one(match);
                state_d = (|match) ? ACCEPT : REJECT;
            end
            ACCEPT: begin
                done_d = done_q | slot_q;
                ok_d   = 1'b1;
                cons_d = 1'b1;
                if (score_q != '1) score_d = score_q + SCORE_W'(1);
                cnt_d   = CNT_LOAD;
                state_d = COOLDOWN;
            end
            REJECT: begin
                bad_d = 1'b1;
                if (miss_q != '1) miss_d = miss_q + MISS_W'(1);
                cnt_d   = CNT_LOAD;
                state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // A replaced order always reopens its slot, even over a same-cycle accept.
        done_d = done_d & ~changed;
    end

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            plate_q <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            score_q <= '0;
            miss_q  <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            cons_q  <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
        end else begin
            state_q <= state_d;
            plate_q <= plate_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            cons_q  <= cons_d;
            for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign orders_done = done_q;
    assign inv_consume = cons_q;
    assign serve_ok    = ok_q;
    assign serve_bad   = bad_q;
    assign all_done    = &done_q;
    assign score       = score_q;
    assign misses      = miss_q;

endmodule

// File: tb/tb_order_checker.sv
// Directed bench for order_checker with a 4-cycle cooldown.
// Each scenario task drives its stimulus and checks inline.
module tb_order_checker;
    import kitchen_pkg::*;

    logic        basys_clk;
    logic        rst_n;
    logic        serve_btn;
    logic [11:0] order_1, order_2, order_3, inventory;
    logic [2:0]  orders_done;
    logic        inv_consume, serve_ok, serve_bad, all_done;
    logic [7:0]  score;
    logic [3:0]  misses;

    int checks;
    int failures;

    order_checker #(
        .COOLDOWN_CYCLES (4),
        .SCORE_W         (8),
        .MISS_W          (4)
    ) dut (
        .basys_clk   (basys_clk),
        .rst_n       (rst_n),
        .serve_btn   (serve_btn),
        .order_1     (order_1),
        .order_2     (order_2),
        .order_3     (order_3),
        .inventory   (inventory),
        .orders_done (orders_done),
        .inv_consume (inv_consume),
        .serve_ok    (serve_ok),
        .serve_bad   (serve_bad),
        .all_done    (all_done),
        .score       (score),
        .misses      (misses)
    );

    initial begin
        basys_clk = 1'b0;
        forever #5 basys_clk = ~basys_clk;
    end

    task automatic step();
        @(posedge basys_clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        serve_btn = 1'b0;
        repeat (2) @(posedge basys_clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    // Press, observe 8 cycles of pulses, release and settle back to IDLE.
    task automatic do_serve(output int n_ok, output int n_bad,
                            output int n_cons, output int first,
                            output int n_both);
        n_ok = 0; n_bad = 0; n_cons = 0; first = 0; n_both = 0;
        serve_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (serve_ok) n_ok++;
            if (serve_bad) n_bad++;
            if (inv_consume) n_cons++;
            if (serve_ok && serve_bad) n_both++;
            if (first == 0 && (serve_ok || serve_bad || inv_consume)) first = i;
            if (i == 5) serve_btn = 1'b0;
        end
        repeat (8) step();
    endtask

    task automatic test_reset();
        order_1 = CHICKEN_RICE; order_2 = ONION_SOUP; order_3 = TOMATO_SOUP;
        inventory = ONION_SOUP;
        rst_n = 1'b0; serve_btn = 1'b0;
        #3;
        checks++;
        if ({orders_done, inv_consume, serve_ok, serve_bad, all_done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0",
                     {orders_done, inv_consume, serve_ok, serve_bad, all_done});
        end
        checks++;
        if ({score, misses} !== 12'h000) begin
            failures++;
            $display("FAIL reset_counters got=%h exp=000", {score, misses});
        end
        @(posedge basys_clk); #1;
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({orders_done, score, misses} !== 15'h0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", {orders_done, score, misses});
        end
    endtask

    task automatic test_single_serve();
        int n_ok, n_bad, n_cons, first, n_both;
        order_1 = CHICKEN_RICE; order_2 = ONION_SOUP; order_3 = TOMATO_SOUP;
        inventory = ONION_SOUP;
        apply_reset();
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        checks++;
        if (first !== 5) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=5", first);
        end
        checks++;
        if ({n_ok, n_bad, n_cons} !== {32'd1, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL single_pulses got ok=%0d bad=%0d cons=%0d exp 1/0/1",
                     n_ok, n_bad, n_cons);
        end
        checks++;
        if (orders_done !== 3'b010 || score !== 8'd1) begin
            failures++;
            $display("FAIL single_state got done=%b score=%0d exp 010/1",
                     orders_done, score);
        end
    endtask

    task automatic test_all_done();
        int n_ok, n_bad, n_cons, first, n_both;
        logic [2:0] exp_done [3];
        exp_done[0] = 3'b001; exp_done[1] = 3'b011; exp_done[2] = 3'b111;
        order_1 = TOMATO_RICE; order_2 = TOMATO_RICE; order_3 = TOMATO_RICE;
        inventory = TOMATO_RICE;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_serve(n_ok, n_bad, n_cons, first, n_both);
            checks++;
            if (orders_done !== exp_done[k] || n_ok !== 1) begin
                failures++;
                $display("FAIL dup_serve%0d got done=%b ok=%0d exp %b/1",
                         k, orders_done, n_ok, exp_done[k]);
            end
        end
        checks++;
        if (all_done !== 1'b1 || score !== 8'd3) begin
            failures++;
            $display("FAIL all_done got all=%b score=%0d exp 1/3", all_done, score);
        end
    endtask

    task automatic test_reject();
        int n_ok, n_bad, n_cons, first, n_both;
        order_1 = CHICKEN_RICE; order_2 = ONION_SOUP; order_3 = TOMATO_SOUP;
        inventory = DISH_EMPTY;
        apply_reset();
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        checks++;
        if ({n_ok, n_bad, n_cons, first} !== {32'd0, 32'd1, 32'd0, 32'd5}) begin
            failures++;
            $display("FAIL empty_reject got ok=%0d bad=%0d cons=%0d at=%0d exp 0/1/0/5",
                     n_ok, n_bad, n_cons, first);
        end
        checks++;
        if (misses !== 4'd1 || orders_done !== 3'b000 || score !== 8'd0) begin
            failures++;
            $display("FAIL empty_state got miss=%0d done=%b score=%0d exp 1/000/0",
                     misses, orders_done, score);
        end
        inventory = TOMATO_RICE;
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        checks++;
        if (n_bad !== 1 || n_cons !== 0 || misses !== 4'd2) begin
            failures++;
            $display("FAIL wrong_dish got bad=%0d cons=%0d miss=%0d exp 1/0/2",
                     n_bad, n_cons, misses);
        end
        for (int k = 0; k < 18; k++) begin
            do_serve(n_ok, n_bad, n_cons, first, n_both);
            checks++;
            if (n_both !== 0) begin
                failures++;
                $display("FAIL ok_bad_overlap got=%0d exp=0", n_both);
            end
        end
        checks++;
        if (misses !== 4'd15 || orders_done !== 3'b000) begin
            failures++;
            $display("FAIL miss_saturate got miss=%0d done=%b exp 15/000",
                     misses, orders_done);
        end
    endtask

    task automatic test_cooldown();
        int n_ok, n_bad, n_cons, first, n_both;
        int late;
        order_1 = TOMATO_RICE; order_2 = TOMATO_RICE; order_3 = TOMATO_RICE;
        inventory = TOMATO_RICE;
        apply_reset();
        late = 0;
        serve_btn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 5) serve_btn = 1'b0;
            if (i == 6) serve_btn = 1'b1;
            if (i > 5 && (serve_ok || serve_bad || inv_consume)) late++;
        end
        serve_btn = 1'b0;
        repeat (8) step();
        checks++;
        if (late !== 0 || score !== 8'd1 || orders_done !== 3'b001) begin
            failures++;
            $display("FAIL cooldown_ignore got late=%0d score=%0d done=%b exp 0/1/001",
                     late, score, orders_done);
        end
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        checks++;
        if (n_ok !== 1 || score !== 8'd2 || orders_done !== 3'b011) begin
            failures++;
            $display("FAIL after_cooldown got ok=%0d score=%0d done=%b exp 1/2/011",
                     n_ok, score, orders_done);
        end
    endtask

    task automatic test_order_change();
        int n_ok, n_bad, n_cons, first, n_both;
        order_1 = CHICKEN_RICE; order_2 = ONION_SOUP; order_3 = TOMATO_SOUP;
        inventory = ONION_SOUP;
        apply_reset();
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        order_2 = TOMATO_SOUP;
        step();
        checks++;
        if (orders_done !== 3'b000) begin
            failures++;
            $display("FAIL order_change_clear got=%b exp=000", orders_done);
        end
        order_2 = ONION_SOUP;
        repeat (2) step();
        n_ok = 0;
        serve_btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (serve_ok) n_ok++;
            if (i == 4) order_2 = TOMATO_SOUP;
            if (i == 5) serve_btn = 1'b0;
        end
        checks++;
        if (n_ok !== 1 || orders_done !== 3'b000 || score !== 8'd2) begin
            failures++;
            $display("FAIL clear_beats_accept got ok=%0d done=%b score=%0d exp 1/000/2",
                     n_ok, orders_done, score);
        end
        repeat (8) step();
    endtask

    task automatic test_abort();
        int n_ok, n_bad, n_cons, first, n_both;
        int seen;
        order_1 = CHICKEN_RICE; order_2 = ONION_SOUP; order_3 = TOMATO_SOUP;
        inventory = ONION_SOUP;
        apply_reset();
        do_serve(n_ok, n_bad, n_cons, first, n_both);
        inventory = CHICKEN_RICE;
        serve_btn = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({orders_done, inv_consume, serve_ok, serve_bad, all_done,
             score, misses} !== 19'h0) begin
            failures++;
            $display("FAIL abort_async got done=%b score=%0d miss=%0d pulses=%b exp all 0",
                     orders_done, score, misses, {inv_consume, serve_ok, serve_bad});
        end
        serve_btn = 1'b0;
        seen = 0;
        repeat (2) @(posedge basys_clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (serve_ok || serve_bad || inv_consume) seen++;
        end
        checks++;
        if (seen !== 0 || score !== 8'd0 || orders_done !== 3'b000) begin
            failures++;
            $display("FAIL abort_no_pulse got seen=%0d score=%0d done=%b exp 0/0/000",
                     seen, score, orders_done);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        serve_btn = 1'b0;
        order_1   = '0;
        order_2   = '0;
        order_3   = '0;
        inventory = '0;
        test_reset();
        test_single_serve();
        test_all_done();
        test_reject();
        test_cooldown();
        test_order_change();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/order_checker.md
# order_checker

Serving-side counterpart of the order generator. It takes the three active 12-bit dish orders and the 12-bit plated-dish ID from the player inventory, then arbitrates a serve-button press against the outstanding orders. It produces the per-slot `orders_done` vector consumed by the menu renderer, plus score/miss counters and an inventory-consume pulse. It sits between the inventory logic and the left OLED menu block, on `basys_clk`.

## Interface
- `COOLDOWN_CYCLES`, 10_000_000: lockout after each serve decision (100 ms at 100 MHz); benches use 4.
- `SCORE_W`, 8: score counter width.
- `MISS_W`, 4: miss counter width.

Ports:
- `basys_clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `serve_btn`  in  1  raw serve pushbutton, asynchronous to the clock.
- `order_1`, `order_2`, `order_3`  in  12 each  current dish order per slot.
- `inventory`  in  12  dish ID currently held; 0 = empty plate.
- `orders_done`  out  3  sticky per-slot fulfilled flags; bit0 = slot 1.
- `inv_consume`  out  1  one-cycle pulse that clears the held plate.
- `serve_ok`  out  1  one-cycle pulse on an accepted serve.
- `serve_bad`  out  1  one-cycle pulse on a rejected serve.
- `all_done`  out  1  high while `orders_done == 3'b111`.
- `score`  out  `SCORE_W`  accepted serves, saturating.
- `misses`  out  `MISS_W`  rejected serves, saturating.

## Operation
- Reset (async, `rst_n` low): state IDLE; all outputs 0; cooldown counter 0; synchronizer FFs 0; order shadow registers 0.
- `serve_btn` passes through a 2-FF synchronizer, then a rising-edge detector (`sync & ~sync_d`).
- State machine:
  - IDLE: when an edge is detected, latch `inventory` into `plate`, then go to CHECK. Edges seen in any other state are discarded.
  - CHECK: compute the match vector. Slot i matches when `order_i == plate`, `orders_done[i] == 0` and `plate != 0`. Pick the lowest-index matching slot, then go to ACCEPT if any slot matches, otherwise REJECT.
  - ACCEPT: set the chosen `orders_done` bit (exactly one bit, even when duplicate orders match), pulse `serve_ok` and `inv_consume`, increment `score` (saturating at all-ones), then go to COOLDOWN.
  - REJECT: pulse `serve_bad` and increment `misses` (saturating), then go to COOLDOWN. Rejecting does not consume the plate. An empty plate (0) is always a REJECT.
  - COOLDOWN: load the counter with `COOLDOWN_CYCLES-1` on entry and count down to 0, then return to IDLE.
- Order change detection runs every cycle in every state:
  - If `order_i` differs from its shadow register, clear `orders_done[i]` and update the shadow.
  - If that clear coincides with an ACCEPT setting the same bit, the clear wins, because the order was replaced.
- `all_done` is combinational from `orders_done`.

## Timing
- Edge at the synchronizer output in cycle N (button rise plus 2 cycles): CHECK in N+1, ACCEPT/REJECT in N+2.
- Outputs are registered, so the pulses and the `orders_done`/`score`/`misses` updates are visible in N+3.
- The next edge is accepted no earlier than N+3+`COOLDOWN_CYCLES`.
- `inv_consume`, `serve_ok` and `serve_bad` are each exactly 1 cycle wide. `serve_ok` and `serve_bad` are never high together.
- `inventory` changing after IDLE has no effect; only the latched `plate` is used.
- `rst_n` asserted mid-operation aborts immediately: no pulse is emitted and all counters clear.

## Structure
- Package `kitchen_pkg`:
  - Dish constants: CHICKEN_RICE = 12'b011_000_001_000, ONION_SOUP = 12'b000_000_000_001, TOMATO_SOUP = 12'b000_001_000_000, TOMATO_RICE = 12'b000_001_001_000, DISH_EMPTY = 12'h000.
  - State encoding: IDLE, CHECK, ACCEPT, REJECT, COOLDOWN.
- Sub-module `btn_sync_edge`: 2-FF synchronizer plus rising-edge pulse, reusable for other buttons.

## Test plan
- Orders {CHICKEN_RICE, ONION_SOUP, TOMATO_SOUP}, inventory ONION_SOUP, one press -> `orders_done` = 3'b010, `score` = 1, one `inv_consume` pulse 5 cycles after the button rise.
- Orders all TOMATO_RICE, three accepted serves of TOMATO_RICE -> `orders_done` steps 001→011→111, `all_done` = 1, `score` = 3.
- Inventory 0 or TOMATO_RICE against non-matching orders -> `serve_bad` pulse, `misses` = 1, no `inv_consume`, `orders_done` unchanged; 20 misses -> `misses` = 15 (saturated).
- A second press during COOLDOWN (`COOLDOWN_CYCLES` = 4) -> ignored, `score` unchanged; a press after cooldown is accepted.
- Slot 2 done, then `order_2` changes ONION_SOUP→TOMATO_SOUP -> `orders_done[1]` clears the next cycle; the same-cycle ACCEPT on slot 2 is also cleared.
- `rst_n` low during CHECK -> no pulses; every output is 0 asynchronously.
